// File: rtl/mem_access_unit.sv
// Load/store front end for a word-organised single-port RAM: byte/half/word
// requests, read-modify-write for sub-word stores, extended sub-word loads.
module mem_access_unit #(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]               ram_wr_data,
  output logic                      ram_wr_en,
  input  logic [31:0]               ram_rd_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [1:0]                state_q, state_d;
  logic                      we_q, signed_q, err_q;
  logic [1:0]                size_q, off_q;
  logic [RAM_ADDR_WIDTH-1:0] widx_q;
  logic [31:0]               wdata_q, word_q, rdata_q;

  logic accept, misalign, bad_size, out_of_range, req_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{sext & b[7]}}, b};
      SZ_H:    r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign accept       = req_valid && (state_q == IDLE);
  assign misalign     = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign bad_size     = (req_size == 2'b11);
  assign out_of_range = |(req_addr >> (RAM_ADDR_WIDTH + 2));
  assign req_err      = misalign || bad_size || out_of_range;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                            state_d = RESP;
          else if (!req_we || req_size != SZ_W)   state_d = READ;
          else                                    state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and visible response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state_q == READ && !we_q)
        rdata_q <= load_extract(ram_rd_data, size_q, off_q, signed_q);
    end
  end

  // Latched request fields and the word captured for read-modify-write
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      off_q    <= req_addr[1:0];
      widx_q   <= req_addr[RAM_ADDR_WIDTH+1:2];
      wdata_q  <= req_wdata;
    end
    if (state_q == READ)
      word_q <= ram_rd_data;
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign ram_addr    = (state_q == IDLE) ? '0 : widx_q;
  assign ram_wr_en   = (state_q == WRITE) && !rst;
  assign ram_wr_data = (state_q == WRITE) ? store_merge(word_q, wdata_q, size_q, off_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level memory model, per-cycle
// output comparison, directed cases plus randomized traffic.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wr_data, ram_rd_data;
  logic        ram_wr_en;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_ADDR_WIDTH(10), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data)
  );

  // RAM attached to the DUT
  logic [31:0] ram [1024];
  assign ram_rd_data = ram[ram_addr];
  always @(posedge clk) if (ram_wr_en) ram[ram_addr] <= ram_wr_data;

  // Reference memory, updated once per completed store
  logic [31:0] ref_mem [1024];

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  bit        exp_ready, exp_valid, exp_wen, exp_err;
  bit [9:0]  exp_addr;
  bit [31:0] exp_rdata, exp_wdata;

  logic [31:0] last_rdata, last_wr_data;
  logic        last_err;
  logic [9:0]  last_wr_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    exp_ready = 1; exp_valid = 0; exp_wen = 0; exp_addr = '0;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(exp_wen));
        chk("ram_addr",  32'(ram_addr),  32'(exp_addr));
        if (exp_valid) begin
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(exp_err));
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
        end
        if (exp_wen) begin
          chk("ram_wr_data", ram_wr_data, exp_wdata);
          last_wr_data = ram_wr_data;
          last_wr_addr = ram_addr;
        end
      end
    end
  endtask

  task automatic run_req(input bit we, input bit [1:0] size, input bit sgn,
                         input bit [31:0] addr, input bit [31:0] wdata, input int stall);
    bit        err;
    bit [9:0]  idx;
    int        sh;
    bit [31:0] word, rd, nw, lane;
    err  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || (addr[31:12] != 0);
    idx  = addr[11:2];
    sh   = 8 * int'(addr[1:0]);
    word = ref_mem[idx];
    rd   = 0;
    nw   = word;
    if (!err && !we) begin
      if (size == 2'b00) begin
        rd = (word >> sh) & 32'hFF;
        if (sgn && rd >= 32'h80) rd = rd | 32'hFFFFFF00;
      end else if (size == 2'b01) begin
        rd = (word >> sh) & 32'hFFFF;
        if (sgn && rd >= 32'h8000) rd = rd | 32'hFFFF0000;
      end else rd = word;
    end
    if (!err && we) begin
      lane = (size == 2'b00) ? 32'hFF : 32'hFFFF;
      if (size == 2'b10) nw = wdata;
      else nw = (word & ~(lane << sh)) | ((wdata & lane) << sh);
    end
    set_idle();
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    req_wdata = $urandom;
    exp_ready = 0; exp_addr = idx;
    if (!err) begin
      if (!we || size != 2'b10) begin
        @(posedge clk); #1;
      end
      if (we) begin
        exp_wen = 1; exp_wdata = nw;
        @(posedge clk); #1;
        exp_wen = 0;
        ref_mem[idx] = nw;
      end
    end
    exp_valid = 1; exp_rdata = rd; exp_err = err;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    set_idle();
  endtask

  initial begin
    bit        r_we, r_sgn;
    bit [1:0]  r_size;
    bit [31:0] r_addr;
    rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 0;
    set_idle();
    fork compare_loop(); join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'h1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'h0);
    chk("reset ram_wr_en", 32'(ram_wr_en), 32'h0);
    chk("reset ram_addr", 32'(ram_addr), 32'h0);
    chk("reset ram_wr_data", ram_wr_data, 32'h0);
    rst = 0;
    chk_en = 1;

    // Known contents for words 0..15
    for (int i = 0; i < 16; i++) run_req(1, 2'b10, 0, 32'(i * 4), $urandom, 0);

    run_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    chk("word store addr", 32'(last_wr_addr), 32'h4);
    chk("word store data", last_wr_data, 32'hDEADBEEF);
    chk("word store err", 32'(last_err), 32'h0);
    run_req(0, 2'b10, 0, 32'h10, 0, 0);
    chk("word load", last_rdata, 32'hDEADBEEF);

    run_req(1, 2'b10, 0, 32'h10, 32'h11223344, 0);
    run_req(1, 2'b00, 0, 32'h12, 32'h000000AA, 1);
    chk("byte rmw data", last_wr_data, 32'h11AA3344);

    run_req(1, 2'b10, 0, 32'h10, 32'h8001FF7F, 0);
    run_req(0, 2'b00, 1, 32'h11, 0, 0);
    chk("lb signed", last_rdata, 32'hFFFFFFFF);
    run_req(0, 2'b00, 0, 32'h10, 0, 0);
    chk("lbu", last_rdata, 32'h0000007F);
    run_req(0, 2'b01, 1, 32'h12, 0, 0);
    chk("lh signed", last_rdata, 32'hFFFF8001);

    run_req(1, 2'b01, 0, 32'h13, 32'h1234, 0);
    chk("err half misaligned", 32'(last_err), 32'h1);
    run_req(0, 2'b10, 0, 32'h02, 0, 0);
    chk("err word misaligned", 32'(last_err), 32'h1);
    run_req(1, 2'b11, 0, 32'h10, 32'h5, 0);
    chk("err size 11", 32'(last_err), 32'h1);
    run_req(1, 2'b10, 0, 32'h1000, 32'h77, 0);
    chk("err out of range", 32'(last_err), 32'h1);

    run_req(0, 2'b10, 0, 32'h10, 0, 5);
    chk("backpressure rdata", last_rdata, 32'h8001FF7F);

    // Reset during the WRITE cycle of a word store
    run_req(1, 2'b10, 0, 32'h20, 32'h00000055, 0);
    run_req(0, 2'b10, 0, 32'h20, 0, 0);
    req_we = 1; req_size = 2'b10; req_signed = 0; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    exp_ready = 0; exp_addr = 10'd8; exp_wen = 0;
    @(posedge clk); #1;
    rst = 0;
    set_idle();
    chk("post-reset rsp_rdata", rsp_rdata, 32'h0);
    chk("post-reset rsp_err", 32'(rsp_err), 32'h0);
    chk("post-reset ram_wr_data", ram_wr_data, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("ram unchanged by reset", ram[8], 32'h00000055);
    run_req(0, 2'b10, 0, 32'h20, 0, 0);

    // Randomized traffic over words 0..15
    for (int n = 0; n < 300; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_sgn  = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) r_addr = r_addr | (32'h1 << $urandom_range(12, 31));
      run_req(r_we, r_size, r_sgn, r_addr, $urandom, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < 16; i++) chk("final ram contents", ram[i], ref_mem[i]);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
